// File: rtl/counter_bus.sv
// Host register window onto the four encoder counters over the AVR multiplexed bus.
// Counters are snapshotted together on command, then read bytewise so a count is never torn.
module counter_bus #(
    parameter int cw = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [cw-1:0] count0,
    input  logic [cw-1:0] count1,
    input  logic [cw-1:0] count2,
    input  logic [cw-1:0] count3,
    input  logic [3:0]    err,
    input  logic          ale,
    input  logic          rd,
    input  logic          wr,
    inout  wire  [7:0]    ad
);

    localparam logic [3:0] ADDR_STATUS  = 4'd8;
    localparam logic [3:0] ADDR_CONTROL = 4'd9;

    // Bus synchronisers plus the "previous" stage used for edge detection
    logic       r_ale_s1, r_ale_s2, r_ale_p;
    logic       r_rd_s1, r_rd_s2;
    logic       r_wr_s1, r_wr_s2, r_wr_p;
    logic [7:0] r_ad_s1, r_ad_s2;

    logic       r_ale_fall, r_wr_rise;
    logic [3:0] r_ale_addr;
    logic [3:0] r_wr_data;
    logic [3:0] r_addr;
    logic [7:0] r_rdata;
    logic [3:0] r_flags;
    logic       r_snap_pend;
    logic [cw-1:0] r_snap [4];

    logic [cw-1:0] w_count [4];
    logic          w_ale_fall, w_wr_rise;
    logic [3:0]    w_clr;
    logic          w_snap_cmd;
    logic [15:0]   w_ext;
    logic [7:0]    w_rmap;
    logic          w_unused_ad;

    assign w_count[0] = count0;
    assign w_count[1] = count1;
    assign w_count[2] = count2;
    assign w_count[3] = count3;

    // Only the low nibble of the bus carries address or command bits
    assign w_unused_ad = ^r_ad_s2[7:4];

    // NOTE: non-blocking assignments make every stage take its neighbour's pre-edge value;
    // blocking ones would collapse the synchroniser chain into a single flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ale_s1 <= 1'b0;
            r_ale_s2 <= 1'b0;
            r_ale_p  <= 1'b0;
            r_rd_s1  <= 1'b1;
            r_rd_s2  <= 1'b1;
            r_wr_s1  <= 1'b1;
            r_wr_s2  <= 1'b1;
            r_wr_p   <= 1'b1;
            r_ad_s1  <= '0;
            r_ad_s2  <= '0;
        end else begin
            r_ale_s1 <= ale;
            r_ale_s2 <= r_ale_s1;
            r_ale_p  <= r_ale_s2;
            r_rd_s1  <= rd;
            r_rd_s2  <= r_rd_s1;
            r_wr_s1  <= wr;
            r_wr_s2  <= r_wr_s1;
            r_wr_p   <= r_wr_s2;
            r_ad_s1  <= ad;
            r_ad_s2  <= r_ad_s1;
        end
    end

    assign w_ale_fall = r_ale_p & ~r_ale_s2;
    assign w_wr_rise  = r_wr_s2 & ~r_wr_p;

    // Address and write data are taken from the bus value aligned with the strobe phase
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ale_addr <= '0;
            r_wr_data  <= '0;
            r_ale_fall <= 1'b0;
            r_wr_rise  <= 1'b0;
            r_addr     <= '0;
        end else begin
            if (r_ale_s2) begin
                r_ale_addr <= r_ad_s2[3:0];
            end
            if (!r_wr_s2) begin
                r_wr_data <= r_ad_s2[3:0];
            end
            r_ale_fall <= w_ale_fall;
            r_wr_rise  <= w_wr_rise;
            if (r_ale_fall) begin
                r_addr <= r_ale_addr;
            end
        end
    end

    assign w_clr      = (r_wr_rise && r_addr == ADDR_STATUS) ? r_wr_data : 4'b0000;
    assign w_snap_cmd = r_wr_rise && (r_addr == ADDR_CONTROL) && r_wr_data[0];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_ext  = '0;
        w_rmap = '0;
        if (!r_addr[3]) begin
            w_ext  = 16'(r_snap[r_addr[2:1]]);
            w_rmap = r_addr[0] ? w_ext[15:8] : w_ext[7:0];
        end else if (r_addr == ADDR_STATUS) begin
            w_rmap = {4'b0000, r_flags};
        end
    end

    // NOTE: the snapshot array is a handful of flops, not a RAM, so it is reset
    // like any other register; a read after reset must return zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_flags     <= '0;
            r_snap_pend <= 1'b0;
            r_rdata     <= '0;
            for (int i = 0; i < 4; i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            // A set arriving in the same cycle as a clear wins
            r_flags     <= (r_flags & ~w_clr) | err;
            r_snap_pend <= w_snap_cmd;
            if (r_snap_pend) begin
                for (int i = 0; i < 4; i++) begin
                    r_snap[i] <= w_count[i];
                end
            end
            if (r_rd_s2) begin
                r_rdata <= w_rmap;
            end
        end
    end

    // Pin driver follows raw rd so the bus turns around with no clock latency
    assign ad = rd ? 8'bzzzz_zzzz : r_rdata;

endmodule

// File: tb/tb_counter_bus.sv
// Bench for counter_bus: drives the AVR bus protocol and compares every read byte
// against a register-map model updated from host writes and error pulses.
module tb_counter_bus;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cnt [4];
    logic [3:0]  err;
    logic        ale, rd, wr;
    wire  [7:0]  ad;
    logic [7:0]  tb_ad;
    logic        tb_oe;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_snap [4];
    logic [3:0]  m_flags;

    assign ad = tb_oe ? tb_ad : 8'bzzzz_zzzz;

    // Bus pull-ups make a released bus read as 0xFF
    for (genvar gi = 0; gi < 8; gi++) begin : g_pu
        pullup (ad[gi]);
    end

    counter_bus #(.cw(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .count0(cnt[0]),
        .count1(cnt[1]),
        .count2(cnt[2]),
        .count3(cnt[3]),
        .err   (err),
        .ale   (ale),
        .rd    (rd),
        .wr    (wr),
        .ad    (ad)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int a);
        if (a < 8) begin
            return (a % 2 == 1) ? m_snap[a / 2][15:8] : m_snap[a / 2][7:0];
        end
        if (a == 8) begin
            return {4'h0, m_flags};
        end
        return 8'h00;
    endfunction

    task automatic bus_addr(input logic [3:0] a);
        tb_ad = {4'hA, a};
        tb_oe = 1'b1;
        ale   = 1'b1;
        repeat (3) @(negedge clk);
        ale = 1'b0;
        repeat (2) @(negedge clk);
        tb_oe = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        bus_addr(a);
        repeat (4) @(negedge clk);
        rd = 1'b0;
        repeat (4) @(negedge clk);
        d  = ad;
        rd = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // err_mask is pulsed in the cycle the write itself takes effect
    task automatic host_write(input logic [3:0] a, input logic [7:0] d, input logic [3:0] err_mask);
        bus_addr(a);
        tb_ad = d;
        tb_oe = 1'b1;
        wr    = 1'b0;
        repeat (3) @(negedge clk);
        wr = 1'b1;
        repeat (3) @(negedge clk);
        err = err_mask;
        @(negedge clk);
        err = 4'h0;
        @(negedge clk);
        tb_oe = 1'b0;
        if (a == 4'd8) m_flags = m_flags & ~d[3:0];
        m_flags = m_flags | err_mask;
        if (a == 4'd9 && d[0]) m_snap = cnt;
    endtask

    task automatic pulse_err(input logic [3:0] mask);
        err = mask;
        @(negedge clk);
        err = 4'h0;
        repeat (2) @(negedge clk);
        m_flags = m_flags | mask;
    endtask

    task automatic host_check(input int a, input string tag);
        logic [7:0] got;
        bus_read(4'(a), got);
        check(tag, got, exp_byte(a));
    endtask

    initial begin
        logic [7:0] rb;
        rst = 1'b0; rd = 1'b1; wr = 1'b1; ale = 1'b0; err = 4'h0;
        tb_ad = 8'h00; tb_oe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cnt[i]    = 16'h0;
            m_snap[i] = 16'h0;
        end
        m_flags = 4'h0;

        // Reset: bus released with rd high, driven as 0x00 with rd low
        repeat (3) @(negedge clk);
        check("reset_ad_released", ad, 8'hFF);
        rd = 1'b0;
        #1;
        check("reset_ad_rd_low", ad, 8'h00);
        rd = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int a = 0; a <= 8; a++) host_check(a, "reset_read");

        // Snapshot atomicity across a carry on the live counter
        cnt[0] = 16'h12FF;
        host_write(4'd9, 8'h01, 4'h0);
        cnt[0] = 16'h1300;
        host_check(0, "atomic_lo");
        host_check(1, "atomic_hi");

        // All channels
        cnt[0] = 16'h0102; cnt[1] = 16'h0304; cnt[2] = 16'h0506; cnt[3] = 16'h0708;
        host_write(4'd9, 8'h01, 4'h0);
        for (int a = 0; a < 8; a++) host_check(a, "all_channels");

        // Error flags: set, W1C, and set beating a simultaneous clear
        pulse_err(4'b0101);
        host_check(8, "err_set");
        host_write(4'd8, 8'h01, 4'h0);
        host_check(8, "err_w1c");
        host_write(4'd8, 8'h04, 4'b0100);
        host_check(8, "err_set_wins");

        // Read hold. Old low byte 0x39 lets the DUT-driven bus itself supply
        // address 9 and command bit 0 while rd stays low.
        cnt[0] = 16'hA539;
        host_write(4'd9, 8'h01, 4'h0);
        cnt[0] = 16'h5A7E;
        bus_addr(4'd0);
        repeat (4) @(negedge clk);
        rd = 1'b0;
        #1;
        check("hold_ad_enable", ad, 8'h39);
        repeat (4) @(negedge clk);
        ale = 1'b1;
        repeat (3) @(negedge clk);
        ale = 1'b0;
        repeat (2) @(negedge clk);
        wr = 1'b0;
        repeat (3) @(negedge clk);
        wr = 1'b1;
        repeat (6) @(negedge clk);
        m_snap = cnt;
        check("hold_ad_stable", ad, 8'h39);
        rd = 1'b1;
        repeat (3) @(negedge clk);
        host_check(0, "hold_new_lo");
        host_check(1, "hold_new_hi");

        // Reset between the write strobe and its synchronised rise
        cnt[0] = 16'h1111; cnt[1] = 16'h2222; cnt[2] = 16'h3333; cnt[3] = 16'h4444;
        bus_addr(4'd9);
        tb_ad = 8'h01;
        tb_oe = 1'b1;
        wr    = 1'b0;
        repeat (3) @(negedge clk);
        wr  = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst   = 1'b1;
        tb_oe = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4; i++) m_snap[i] = 16'h0;
        m_flags = 4'h0;
        for (int a = 0; a <= 8; a++) host_check(a, "reset_mid_write");

        // Randomised traffic against the model
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < 4; i++) cnt[i] = 16'($urandom);
            rb = 8'($urandom);
            host_write(4'd9, rb, 4'h0);
            pulse_err(4'($urandom));
            rb = 8'($urandom);
            host_write(4'd8, rb, 4'($urandom));
            rb = 8'($urandom);
            host_write(4'($urandom_range(10, 15)), rb, 4'h0);
            for (int r = 0; r < 3; r++) host_check(int'($urandom_range(0, 15)), "random_read");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
